// File: rtl/loader_pkg.sv
// Shared constants for the serial program loader: FSM encodings, the sync byte
// and the bit-period calculation.
package loader_pkg;

    localparam logic [2:0] ST_SYNC   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_BITS  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer, mid-bit sampling and
// start-bit glitch rejection.
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rxd,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic [7:0] rx_byte
);

    localparam int unsigned CNT_W = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    // sync[1] is the synchronized line, sync[2] its previous value for edge detect
    logic [2:0]       sync;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 3'b111;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_byte  <= '0;
        end else begin
            sync     <= {sync[1:0], rxd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (clr) begin
                rx_state <= RX_IDLE;
                cnt      <= '0;
                bit_cnt  <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (sync[2] && !sync[1]) begin
                            rx_state <= RX_START;
                            cnt      <= '0;
                        end
                    end
                    RX_START: begin
                        if (cnt == HALF_M1) begin
                            cnt     <= '0;
                            bit_cnt <= '0;
                            rx_state <= sync[1] ? RX_IDLE : RX_BITS;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_BITS: begin
                        if (cnt == DIV_M1) begin
                            cnt   <= '0;
                            shreg <= {sync[1], shreg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                rx_state <= RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt == DIV_M1) begin
                            cnt      <= '0;
                            rx_state <= RX_IDLE;
                            if (sync[1]) begin
                                rx_valid <= 1'b1;
                                rx_byte  <= shreg;
                            end else begin
                                rx_ferr <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: parses A5/LEN/data frames from the UART and writes
// little-endian words into instruction memory while holding the CPU in reset.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              load_req,
    output logic              imem_we,
    output logic [31:0]       imem_wa,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);

    logic        rx_valid;
    logic        rx_ferr;
    logic [7:0]  rx_byte;

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] part;
    logic [15:0] len_word;
    logic [15:0] wc_ext;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_req),
        .rxd      (rxd),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .rx_byte  (rx_byte)
    );

    assign len_word = {rx_byte, len_lo};
    assign wc_ext   = 16'(word_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SYNC;
            len_lo     <= '0;
            len        <= '0;
            byte_idx   <= '0;
            part       <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_wa    <= '0;
            imem_wd    <= '0;
        end else begin
            imem_we <= 1'b0;
            if (load_req) begin
                state      <= ST_SYNC;
                word_count <= '0;
                part       <= '0;
                byte_idx   <= '0;
            end else if (rx_ferr && (state inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA})) begin
                state    <= ST_ERR;
                part     <= '0;
                byte_idx <= '0;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (rx_valid && rx_byte == SYNC_BYTE) state <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        if (rx_valid) begin
                            len_lo <= rx_byte;
                            state  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_valid) begin
                            len <= len_word;
                            if (len_word == 16'd0) begin
                                state <= ST_RUN;
                            end else if ({1'b0, len_word} > MAX_LEN) begin
                                state <= ST_ERR;
                            end else begin
                                word_count <= '0;
                                byte_idx   <= '0;
                                state      <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        // Completion is checked one cycle after the last strobe so
                        // the release trails the final imem_we by exactly one cycle.
                        if (wc_ext == len) begin
                            state <= ST_RUN;
                        end else if (rx_valid) begin
                            byte_idx <= byte_idx + 1'b1;
                            case (byte_idx)
                                2'd0: part[7:0]   <= rx_byte;
                                2'd1: part[15:8]  <= rx_byte;
                                2'd2: part[23:16] <= rx_byte;
                                default: begin
                                    imem_we    <= 1'b1;
                                    imem_wd    <= {rx_byte, part};
                                    imem_wa    <= 32'({word_count, 2'b00});
                                    word_count <= word_count + 1'b1;
                                    part       <= '0;
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done     = (state == ST_RUN);
    assign cpu_hold = (state != ST_RUN);
    assign err      = (state == ST_ERR);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares each imem_we.
module tb_uart_prog_loader;

    localparam int unsigned DIV = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        load_req;
    logic        imem_we;
    logic [31:0] imem_wa;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    logic done_q = 1'b0;
    logic [63:0] exp_q[$];
    logic [7:0]  fr[$];

    always #10 clk = ~clk;

    uart_prog_loader #(
        .CLK_FREQ (1_152_000),
        .BAUD     (115200),
        .ADDR_W   (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_wa    (imem_wa),
        .imem_wd    (imem_wd),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (imem_we) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_wa, imem_wd);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_wa, e[63:32]);
                chk("write_data", imem_wd, e[31:0]);
            end
        end
        if (done && !done_q) done_cyc = cyc;
        done_q = done;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (DIV) @(posedge clk);
        #1;
        rxd = 1'b1;
        if (!stop) begin
            repeat (DIV) @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
        repeat (2 * DIV) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        @(posedge clk);
        #1 load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_we"},   32'(imem_we),  32'd0);
        chk({tag, "_wa"},   imem_wa,       32'd0);
        chk({tag, "_wd"},   imem_wd,       32'd0);
        chk({tag, "_done"}, 32'(done),     32'd0);
        chk({tag, "_err"},  32'(err),      32'd0);
        chk({tag, "_wc"},   32'(word_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        load_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset("por");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Two-word load
        exp_q.push_back({32'd0, 32'h00A00513});
        exp_q.push_back({32'd4, 32'h00500593});
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        send_frame(fr);
        chk("two_wc", 32'(word_count), 32'd2);
        chk("two_done", 32'(done), 32'd1);
        chk("two_hold", 32'(cpu_hold), 32'd0);
        chk("two_done_lag", 32'(done_cyc - last_we_cyc), 32'd1);

        // Reset asserted in the middle of a bit
        rxd = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #2 chk_reset("midbit_rst");
        #10 rxd = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1 chk_reset("post_rst");
        repeat (3 * DIV) @(posedge clk);
        #1;

        // Junk before sync, then one word
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (DIV) @(posedge clk);
        #1;
        chk("junk_hold", 32'(cpu_hold), 32'd1);
        chk("junk_err", 32'(err), 32'd0);
        chk("junk_wc", 32'(word_count), 32'd0);
        exp_q.push_back({32'd0, 32'hDEADBEEF});
        fr = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(fr);
        chk("one_done", 32'(done), 32'd1);
        chk("one_wc", 32'(word_count), 32'd1);

        // Abort from RUN
        pulse_load();
        chk("abort_hold", 32'(cpu_hold), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wc", 32'(word_count), 32'd0);

        // Framing error on the second data byte
        fr = '{8'hA5, 8'h02, 8'h00, 8'h11};
        send_frame(fr);
        send_byte(8'h22, 1'b0);
        chk("ferr_err", 32'(err), 32'd1);
        chk("ferr_hold", 32'(cpu_hold), 32'd1);
        fr = '{8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(fr);
        chk("ferr_stays", 32'(err), 32'd1);
        pulse_load();
        chk("ferr_clear_err", 32'(err), 32'd0);
        chk("ferr_clear_hold", 32'(cpu_hold), 32'd1);

        // LEN = 0
        fr = '{8'hA5, 8'h00, 8'h00};
        send_frame(fr);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_wc", 32'(word_count), 32'd0);
        pulse_load();

        // LEN = 65
        fr = '{8'hA5, 8'h41, 8'h00};
        send_frame(fr);
        chk("len65_err", 32'(err), 32'd1);
        pulse_load();

        // LEN = 64, word i byte j = i*4+j
        fr = '{8'hA5, 8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b0;
            b0 = 8'(i * 4);
            exp_q.push_back({32'(i * 4), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            for (int j = 0; j < 4; j++) fr.push_back(b0 + 8'(j));
        end
        send_frame(fr);
        chk("len64_wc", 32'(word_count), 32'd64);
        chk("len64_done", 32'(done), 32'd1);
        chk("len64_last_wa", imem_wa, 32'd252);
        pulse_load();

        // Reset after two bytes of the first word, then resend
        fr = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
        send_frame(fr);
        rxd = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #3 rst = 1'b1;
        #10 rxd = 1'b1;
        rst = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        exp_q.push_back({32'd0, 32'h44332211});
        fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(fr);
        chk("rst_reload_done", 32'(done), 32'd1);
        chk("rst_reload_wc", 32'(word_count), 32'd1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
